data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Byte-addressable data RAM for the single-cycle RISC-V datapath.
//  Executes SB/SH/SW stores on the clock edge. Returns LB/LH/LW/LBU/LHU
//  load data combinationally as read_data, which feeds the mem_to_reg
//  write-back select.
//  Detects misaligned, out-of-range and unsupported-size accesses, and
//  logs the first fault in sticky registers for debug.
// PARAMETERS
//  DEPTH  256  number of 32-bit words (power of 2, >= 2); AW = $clog2(DEPTH)
//  XLEN   32   data/address width (fixed at 32; no other value is supported)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  mem_read    in   1   load strobe from control unit
//  mem_write   in   1   store strobe from control unit
//  funct3      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr        in   32  byte address from ALU result
//  write_data  in   32  store data (rs2); low bits used for B/H
//  err_clr     in   1   synchronous clear of the sticky fault registers
//  read_data   out  32  extended load data; 0 when no valid load
//  fault       out  1   combinational fault on the current access
//  err_flag    out  1   sticky: a fault has occurred since reset or clear
//  err_addr    out  32  address of the first fault captured while err_flag=0
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All DEPTH words, err_flag and err_addr go to 0 immediately.
//   - read_data reflects the cleared array (0).
//  Decode:
//   - Word index = addr[AW+1:2]; lane = addr[1:0].
//   - access = mem_read | mem_write.
//  Fault (combinational; asserted only when access=1):
//   - H/HU with addr[0]=1.
//   - W with addr[1:0]!=0.
//   - funct3 not in {000,001,010,100,101}. For stores, only 000/001/010 are legal.
//   - addr >= 4*DEPTH (range check on the full 32 bits).
//  Store (posedge clk, mem_write=1, fault=0):
//   - SB writes byte lane addr[1:0] with write_data[7:0].
//   - SH writes half addr[1] with write_data[15:0].
//   - SW writes the whole word.
//   - Other lanes are untouched. A faulting store writes nothing.
//  Load (combinational, mem_read=1, fault=0):
//   - Select byte/half by lane.
//   - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
//   - mem_read=0 or fault=1 gives read_data = 0.
//  Simultaneous mem_read and mem_write:
//   - The store commits at the edge.
//   - read_data shows pre-edge contents during that cycle (read-before-write).
//  Sticky log (posedge clk):
//   - err_clr=1 clears err_flag and err_addr to 0. err_clr has priority over a
//     new fault in the same cycle.
//   - Otherwise, fault=1 with err_flag=0 sets err_flag=1 and err_addr=addr.
//   - Later faults do not overwrite err_addr until it is cleared.
//  Latency: loads 0 cycles (same-cycle), stores 1 edge.
//  Reset mid-operation: an async reset asserted in a store cycle aborts the
//   store; the array stays 0.
//  The block never stalls; there is no handshake (single-cycle core).
// TESTING
//  1. Reset, then LW addr 0x0 -> read_data=0; fault=0; err_flag=0.
//  2. SW 0x8 data 0x80FF7F01, then next cycle:
//     - LW 0x8 -> 0x80FF7F01.
//     - LB 0x8 -> 0x00000001.
//     - LB 0xB -> 0xFFFFFF80.
//     - LBU 0xB -> 0x00000080.
//     - LH 0xA -> 0xFFFF80FF.
//     - LHU 0xA -> 0x000080FF.
//  3. After test 2, SB 0x9 data 0xAA then SH 0xA data 0x1234 -> LW 0x8 = 0x1234AA01.
//  4. SW 0x6 data 0xDEADBEEF -> fault=1, memory unchanged, err_flag=1,
//     err_addr=0x6. Then LH 0x3 (fault) -> err_addr stays 0x6. Then err_clr=1
//     -> err_flag=0, err_addr=0.
//  5. With DEPTH=256, SW 0x400 -> fault=1, no write, err_addr=0x400.
//     LW 0x3FC after SW 0x3FC data 0x5 -> read_data=0x5.
//  6. Same cycle mem_read=mem_write=1, SW 0x10 data 0x7 over old 0x3 -> read_data=0x3
//     that cycle, 0x7 after the edge. Async rst_n pulse mid-cycle -> array 0,
//     err_flag=0.

Source files
------------

// File: rtl/data_memory_if.sv
// Core-to-data-RAM bus: load/store strobes, size, address, data and fault/debug returns.
interface data_memory_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        err_clr;
    logic [31:0] read_data;
    logic        fault;
    logic        err_flag;
    logic [31:0] err_addr;

    modport master (
        output mem_read, mem_write, funct3, addr, write_data, err_clr,
        input  read_data, fault, err_flag, err_addr
    );

    modport slave (
        input  mem_read, mem_write, funct3, addr, write_data, err_clr,
        output read_data, fault, err_flag, err_addr
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable data RAM for a single-cycle RISC-V core: edge-committed stores,
// combinational sign/zero-extended loads, fault detection and a sticky first-fault log.
module data_memory #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned XLEN  = 32
) (
    input logic          clk,
    input logic          rst_n,
    data_memory_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic            err_flag_q;
    logic [XLEN-1:0] err_addr_q;

    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            access;
    logic            size_bad;
    logic            out_of_range;
    logic            fault;
    logic [XLEN-1:0] rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] wr_word;

    assign word_idx     = bus.addr[AW+1:2];
    assign lane         = bus.addr[1:0];
    assign access       = bus.mem_read | bus.mem_write;
    // Any set bit above the array's byte span means addr >= 4*DEPTH.
    assign out_of_range = |bus.addr[XLEN-1:AW+2];
    assign fault        = access & (size_bad | out_of_range);

    always_comb begin
        size_bad = 1'b0;
        case (bus.funct3)
            3'b000:  size_bad = 1'b0;
            3'b001:  size_bad = bus.addr[0];
            3'b010:  size_bad = |bus.addr[1:0];
            3'b100:  size_bad = bus.mem_write;
            3'b101:  size_bad = bus.mem_write | bus.addr[0];
            default: size_bad = 1'b1;
        endcase
    end

    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];

        wr_word = rd_word;
        case (bus.funct3[1:0])
            2'b00:   wr_word[{lane, 3'b000} +: 8] = bus.write_data[7:0];
            2'b01:   wr_word[{bus.addr[1], 4'b0000} +: 16] = bus.write_data[15:0];
            default: wr_word = bus.write_data;
        endcase

        bus.read_data = '0;
        if (bus.mem_read && !fault) begin
            case (bus.funct3)
                3'b000:  bus.read_data = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  bus.read_data = {{16{rd_half[15]}}, rd_half};
                3'b100:  bus.read_data = {24'h0, rd_byte};
                3'b101:  bus.read_data = {16'h0, rd_half};
                default: bus.read_data = rd_word;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.mem_write && !fault) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // Clear wins over a fault in the same cycle; only the first fault is logged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (bus.err_clr) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (fault && !err_flag_q) begin
            err_flag_q <= 1'b1;
            err_addr_q <= bus.addr;
        end
    end

    assign bus.fault    = fault;
    assign bus.err_flag = err_flag_q;
    assign bus.err_addr = err_addr_q;
endmodule

// File: tb/tb_data_memory.sv
// Directed table-driven bench for data_memory plus hand-written reset sequences.
module tb_data_memory;
    logic clk;
    logic rst_n;

    data_memory_if bus ();

    data_memory #(.DEPTH(256), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_flag;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic clr,
                       input logic [31:0] erd, input logic ef, input logic efl,
                       input logic [31:0] eea);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.clr = clr; v.exp_rdata = erd; v.exp_fault = ef; v.exp_flag = efl; v.exp_eaddr = eea;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
        bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3;
        bus.addr = addr; bus.write_data = wdata; bus.err_clr = clr;
    endtask

    initial begin
        // name           rd wr f3      addr          wdata          clr  rdata          flt flag eaddr
        add("lw0_reset",   1, 0, 3'b010, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h0);
        add("sw8",         0, 1, 3'b010, 32'h8,        32'h80FF7F01,  0, 32'h0,         0, 0, 32'h0);
        add("lw8",         1, 0, 3'b010, 32'h8,        32'h0,         0, 32'h80FF7F01,  0, 0, 32'h0);
        add("lb8",         1, 0, 3'b000, 32'h8,        32'h0,         0, 32'h00000001,  0, 0, 32'h0);
        add("lbB",         1, 0, 3'b000, 32'hB,        32'h0,         0, 32'hFFFFFF80,  0, 0, 32'h0);
        add("lbuB",        1, 0, 3'b100, 32'hB,        32'h0,         0, 32'h00000080,  0, 0, 32'h0);
        add("lhA",         1, 0, 3'b001, 32'hA,        32'h0,         0, 32'hFFFF80FF,  0, 0, 32'h0);
        add("lhuA",        1, 0, 3'b101, 32'hA,        32'h0,         0, 32'h000080FF,  0, 0, 32'h0);
        add("sb9",         0, 1, 3'b000, 32'h9,        32'hFFFFFFAA,  0, 32'h0,         0, 0, 32'h0);
        add("shA",         0, 1, 3'b001, 32'hA,        32'hFFFF1234,  0, 32'h0,         0, 0, 32'h0);
        add("lw8_merged",  1, 0, 3'b010, 32'h8,        32'h0,         0, 32'h1234AA01,  0, 0, 32'h0);
        add("sw6_misal",   0, 1, 3'b010, 32'h6,        32'hDEADBEEF,  0, 32'h0,         1, 0, 32'h0);
        add("lw4_unchg",   1, 0, 3'b010, 32'h4,        32'h0,         0, 32'h0,         0, 1, 32'h6);
        add("lh3_misal",   1, 0, 3'b001, 32'h3,        32'h0,         0, 32'h0,         1, 1, 32'h6);
        add("idle_keep",   0, 0, 3'b000, 32'h0,        32'h0,         0, 32'h0,         0, 1, 32'h6);
        add("clr",         0, 0, 3'b000, 32'h0,        32'h0,         1, 32'h0,         0, 1, 32'h6);
        add("after_clr",   0, 0, 3'b000, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h0);
        add("sw400_oor",   0, 1, 3'b010, 32'h400,      32'h5,         0, 32'h0,         1, 0, 32'h0);
        add("lw0_noalias", 1, 0, 3'b010, 32'h0,        32'h0,         0, 32'h0,         0, 1, 32'h400);
        add("sw3FC",       0, 1, 3'b010, 32'h3FC,      32'h5,         0, 32'h0,         0, 1, 32'h400);
        add("lw3FC",       1, 0, 3'b010, 32'h3FC,      32'h0,         0, 32'h5,         0, 1, 32'h400);
        add("lw_hi_oor",   1, 0, 3'b010, 32'h8000_0008, 32'h0,        0, 32'h0,         1, 1, 32'h400);
        add("clr_vs_flt",  1, 0, 3'b001, 32'h1,        32'h0,         1, 32'h0,         1, 1, 32'h400);
        add("clr_wins",    0, 0, 3'b000, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h0);
        add("f3_011",      1, 0, 3'b011, 32'h20,       32'h0,         0, 32'h0,         1, 0, 32'h0);
        add("st_f3_100",   0, 1, 3'b100, 32'h10,       32'h3,         0, 32'h0,         1, 1, 32'h20);
        add("sw10",        0, 1, 3'b010, 32'h10,       32'h3,         0, 32'h0,         0, 1, 32'h20);
        add("lw10_old",    1, 0, 3'b010, 32'h10,       32'h0,         0, 32'h3,         0, 1, 32'h20);
        add("rw_same",     1, 1, 3'b010, 32'h10,       32'h7,         0, 32'h3,         0, 1, 32'h20);
        add("lw10_new",    1, 0, 3'b010, 32'h10,       32'h0,         0, 32'h7,         0, 1, 32'h20);
        add("sh2",         0, 1, 3'b001, 32'h2,        32'h0000BEEF,  0, 32'h0,         0, 1, 32'h20);
        add("lw0_hi_half", 1, 0, 3'b010, 32'h0,        32'h0,         0, 32'hBEEF0000,  0, 1, 32'h20);
        add("lh2_neg",     1, 0, 3'b001, 32'h2,        32'h0,         0, 32'hFFFFBEEF,  0, 1, 32'h20);
        add("no_read",     0, 0, 3'b010, 32'h0,        32'h0,         0, 32'h0,         0, 1, 32'h20);
        add("idle_badf3",  0, 0, 3'b111, 32'h401,      32'h0,         0, 32'h0,         0, 1, 32'h20);

        drive(0, 0, 3'b000, 32'h0, 32'h0, 0);
        rst_n = 1'b0;
        #2;
        check("reset_flag", {31'h0, bus.err_flag}, 32'h0);
        check("reset_eaddr", bus.err_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
            #2;
            check({vecs[i].name, ".rdata"}, bus.read_data, vecs[i].exp_rdata);
            check({vecs[i].name, ".fault"}, {31'h0, bus.fault}, {31'h0, vecs[i].exp_fault});
            check({vecs[i].name, ".flag"}, {31'h0, bus.err_flag}, {31'h0, vecs[i].exp_flag});
            check({vecs[i].name, ".eaddr"}, bus.err_addr, vecs[i].exp_eaddr);
        end

        // Async reset asserted mid-cycle during a store: store aborted, array and log cleared.
        @(negedge clk);
        drive(0, 1, 3'b010, 32'h10, 32'h9, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_flag", {31'h0, bus.err_flag}, 32'h0);
        check("rst_async_eaddr", bus.err_addr, 32'h0);
        @(negedge clk);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        #1;
        check("rst_lw10", bus.read_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        #2;
        check("post_rst_lw10", bus.read_data, 32'h0);
        check("post_rst_flag", {31'h0, bus.err_flag}, 32'h0);
        @(negedge clk);
        drive(1, 0, 3'b010, 32'h0, 32'h0, 0);
        #2;
        check("post_rst_lw0", bus.read_data, 32'h0);
        @(negedge clk);
        drive(1, 0, 3'b010, 32'h3FC, 32'h0, 0);
        #2;
        check("post_rst_lw3FC", bus.read_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
